// File: rtl/parametric_demux_buffered.sv
// parametric_demux_buffered: val/rdy demux with a one-entry register per output channel.
// PARAMETRIC_DEMUX_BUFFERED_DROP_EN: consume and flag messages whose sel is out of range.
module parametric_demux_buffered #(
  parameter int p_nbits = 32,
  parameter int p_noutputs = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic [p_nbits-1:0]                in_msg,
  input  logic [$clog2(p_noutputs)-1:0]     sel,
  output logic [p_noutputs*p_nbits-1:0]     flattened_out_msg,
  output logic [p_noutputs-1:0]             out_val,
  input  logic [p_noutputs-1:0]             out_rdy,
  output logic                              sel_err
);
  localparam int sw = $clog2(p_noutputs);
  logic [p_noutputs-1:0] full, hit;
  logic [p_noutputs-1:0][p_nbits-1:0] data;
  logic sel_ok, rdy_hit, in_fire;
  for (genvar k = 0; k < p_noutputs; k++) begin : g_ch
    assign hit[k] = sel == sw'(k);
    assign flattened_out_msg[(p_noutputs-1-k)*p_nbits +: p_nbits] = data[k];
  end
  // a one-hot match on sel doubles as the range check when p_noutputs is not a power of 2
  assign sel_ok = |hit;
  assign rdy_hit = |(hit & (~full | out_rdy));
  assign in_fire = in_val & in_rdy & sel_ok;
  assign out_val = full;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
      data <= '0;
    end else begin
      for (int k = 0; k < p_noutputs; k++) begin
        if (in_fire && hit[k]) begin
          data[k] <= in_msg;
          full[k] <= 1'b1;
        end else if (out_rdy[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end
`ifdef PARAMETRIC_DEMUX_BUFFERED_DROP_EN
  assign in_rdy = rdy_hit | ~sel_ok;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err <= 1'b0;
    else sel_err <= in_val & ~sel_ok;
  end
`else
  assign in_rdy = rdy_hit;
  assign sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_parametric_demux_buffered.sv
// tb_parametric_demux_buffered: vector table, corner sequences and queue-model random test.
module tb_parametric_demux_buffered;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_val, in_rdy, sel_err;
  logic [7:0] in_msg;
  logic [1:0] sel;
  logic [31:0] flat;
  logic [3:0] out_val, out_rdy;
  logic in_val3, in_rdy3, sel_err3;
  logic [7:0] in_msg3;
  logic [1:0] sel3;
  logic [23:0] flat3;
  logic [2:0] out_val3, out_rdy3;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q [4][$];
  always #5 clk = ~clk;
  parametric_demux_buffered #(.p_nbits(8), .p_noutputs(4)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .sel(sel),
    .flattened_out_msg(flat), .out_val(out_val), .out_rdy(out_rdy), .sel_err(sel_err));
  parametric_demux_buffered #(.p_nbits(8), .p_noutputs(3)) dut3 (
    .clk(clk), .reset(reset), .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3), .sel(sel3),
    .flattened_out_msg(flat3), .out_val(out_val3), .out_rdy(out_rdy3), .sel_err(sel_err3));
  typedef struct packed {
    logic v;
    logic [1:0] s;
    logic [7:0] m;
    logic [3:0] o;
    logic rdy;
    logic [3:0] val;
    logic [31:0] fl;
  } vec_t;
  vec_t tv [17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] msk(input logic [3:0] v);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) if (v[k]) r[(3-k)*8 +: 8] = 8'hFF;
    return r;
  endfunction
  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] m, input logic [3:0] o);
    in_val = v;
    sel = s;
    in_msg = m;
    out_rdy = o;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0000, 32'h00000000};
    tv[1]  = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0001, 32'hA0000000};
    tv[2]  = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0010, 32'h00A10000};
    tv[3]  = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b0100, 32'h0000A200};
    tv[4]  = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b1, 4'b1000, 32'h000000A3};
    tv[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000};
    tv[6]  = '{1'b1, 2'd1, 8'h11, 4'hD, 1'b1, 4'b0000, 32'h00000000};
    tv[7]  = '{1'b1, 2'd1, 8'h22, 4'hD, 1'b0, 4'b0010, 32'h00110000};
    tv[8]  = '{1'b1, 2'd1, 8'h22, 4'hD, 1'b0, 4'b0010, 32'h00110000};
    tv[9]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 32'h00110000};
    tv[10] = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'b0010, 32'h00220000};
    tv[11] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000};
    tv[12] = '{1'b1, 2'd0, 8'h77, 4'hE, 1'b1, 4'b0000, 32'h00000000};
    tv[13] = '{1'b1, 2'd2, 8'h55, 4'hE, 1'b1, 4'b0001, 32'h77000000};
    tv[14] = '{1'b0, 2'd0, 8'h00, 4'hE, 1'b0, 4'b0101, 32'h77005500};
    tv[15] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0001, 32'h77000000};
    tv[16] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000};
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    in_val3 = 1'b0; sel3 = 2'd0; in_msg3 = 8'h00; out_rdy3 = 3'b111;
    #1;
    chk("reset_out_val", {28'd0, out_val}, 32'h0);
    chk("reset_flat", flat, 32'h0);
    chk("reset_sel_err", {31'd0, sel_err}, 32'h0);
    tick; tick;
    reset = 1'b0;
    // reset mid-stream
    drive(1'b1, 2'd1, 8'h31, 4'h0);
    tick;
    drive(1'b1, 2'd2, 8'h32, 4'h0);
    tick;
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    #1;
    chk("mid_out_val", {28'd0, out_val}, 32'h6);
    chk("mid_flat", flat & msk(4'b0110), 32'h00313200);
    reset = 1'b1;
    #1;
    chk("rst_async_out_val", {28'd0, out_val}, 32'h0);
    chk("rst_async_flat", flat, 32'h0);
    tick;
    chk("rst_held_out_val", {28'd0, out_val}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_release_in_rdy", {31'd0, in_rdy}, 32'h1);
    tick;
    // routing, backpressure and isolation vectors
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].v, tv[i].s, tv[i].m, tv[i].o);
      #1;
      chk($sformatf("tv%0d_in_rdy", i), {31'd0, in_rdy}, {31'd0, tv[i].rdy});
      chk($sformatf("tv%0d_out_val", i), {28'd0, out_val}, {28'd0, tv[i].val});
      chk($sformatf("tv%0d_flat", i), flat & msk(tv[i].val), tv[i].fl);
      tick;
    end
    // streaming to ch3
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd3, 8'(i), 4'hF);
      #1;
      chk($sformatf("stream%0d_in_rdy", i), {31'd0, in_rdy}, 32'h1);
      if (i > 0) begin
        chk($sformatf("stream%0d_out_val", i), {28'd0, out_val}, 32'h8);
        chk($sformatf("stream%0d_msg", i), {24'd0, flat[7:0]}, 32'(i - 1));
      end
      tick;
    end
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    #1;
    chk("stream_last_out_val", {28'd0, out_val}, 32'h8);
    chk("stream_last_msg", {24'd0, flat[7:0]}, 32'h9);
    tick;
    chk("stream_drained", {28'd0, out_val}, 32'h0);
    // bad sel on the 3-channel instance
    in_val3 = 1'b1; sel3 = 2'd3; in_msg3 = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      #1;
`ifdef PARAMETRIC_DEMUX_BUFFERED_DROP_EN
      chk($sformatf("badsel%0d_in_rdy", c), {31'd0, in_rdy3}, 32'h1);
      chk($sformatf("badsel%0d_sel_err", c), {31'd0, sel_err3}, (c == 0) ? 32'h0 : 32'h1);
`else
      chk($sformatf("badsel%0d_in_rdy", c), {31'd0, in_rdy3}, 32'h0);
      chk($sformatf("badsel%0d_sel_err", c), {31'd0, sel_err3}, 32'h0);
`endif
      chk($sformatf("badsel%0d_out_val", c), {29'd0, out_val3}, 32'h0);
      tick;
    end
    in_val3 = 1'b0;
    #1;
`ifdef PARAMETRIC_DEMUX_BUFFERED_DROP_EN
    chk("badsel_tail_sel_err", {31'd0, sel_err3}, 32'h1);
`else
    chk("badsel_tail_sel_err", {31'd0, sel_err3}, 32'h0);
`endif
    tick;
    chk("badsel_clear_sel_err", {31'd0, sel_err3}, 32'h0);
    // randomized traffic against per-channel queues of capacity one
    for (int t = 0; t < 400; t++) begin
      logic v, exp_rdy;
      logic [1:0] s;
      logic [3:0] o, ev;
      logic [31:0] ef;
      v = ($urandom % 4) != 0;
      s = 2'($urandom_range(0, 3));
      o = 4'($urandom_range(0, 15));
      drive(v, s, 8'($urandom), o);
      ev = '0;
      ef = '0;
      for (int k = 0; k < 4; k++) if (q[k].size() > 0) begin
        ev[k] = 1'b1;
        ef[(3-k)*8 +: 8] = q[k][0];
      end
      exp_rdy = (q[s].size() == 0) || o[s];
      #1;
      chk($sformatf("rnd%0d_in_rdy", t), {31'd0, in_rdy}, {31'd0, exp_rdy});
      chk($sformatf("rnd%0d_out_val", t), {28'd0, out_val}, {28'd0, ev});
      chk($sformatf("rnd%0d_flat", t), flat & msk(ev), ef);
      chk($sformatf("rnd%0d_sel_err", t), {31'd0, sel_err}, 32'h0);
      for (int k = 0; k < 4; k++) if (o[k] && q[k].size() > 0) void'(q[k].pop_front());
      if (v && exp_rdy) q[s].push_back(in_msg);
      tick;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
